// File: rtl/mgt_01_i_wb_arbiter_pkg.sv
// Shared types and sizing for the MicroGT-01 integer write-back arbiter.
package mgt_01_i_wb_arbiter_pkg;

  localparam int unsigned WB_SOURCES     = 4;
  localparam int unsigned WB_DEPTH       = 2;
  localparam int unsigned WB_WRITE_PORTS = 2;

  typedef logic [31:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef struct packed {
    i_register_e addr;
    data_bus_t   data;
  } wb_entry_t;

  // Source visited at step k of a scan that starts at base and wraps at n.
  function automatic int unsigned rot_idx(int unsigned base, int unsigned k, int unsigned n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/mgt_01_i_wb_arbiter_if.sv
// Result-collection and register-file write bus of the write-back arbiter.
interface mgt_01_i_wb_arbiter_if
  import mgt_01_i_wb_arbiter_pkg::*;
#(
  parameter int unsigned SOURCES     = WB_SOURCES,
  parameter int unsigned WRITE_PORTS = WB_WRITE_PORTS
) ();

  logic [SOURCES-1:0]     res_valid;
  logic [SOURCES-1:0]     res_ready;
  i_register_e            res_addr [SOURCES];
  data_bus_t              res_data [SOURCES];
  logic [WRITE_PORTS-1:0] we;
  i_register_e            wr_iaddr [WRITE_PORTS];
  data_bus_t              wr_idata [WRITE_PORTS];
  logic [31:0]            pend;

  modport master (
    output res_valid, res_addr, res_data,
    input  res_ready, we, wr_iaddr, wr_idata, pend
  );

  modport slave (
    input  res_valid, res_addr, res_data,
    output res_ready, we, wr_iaddr, wr_idata, pend
  );

endinterface

// File: rtl/mgt_01_i_wb_arbiter_fifo.sv
// Per-source result FIFO; exposes every slot plus a valid mask for pending tracking.
module mgt_01_i_wb_arbiter_fifo
  import mgt_01_i_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  wb_entry_t     mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign entries = mem;

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, AW'(AW'(i) - rd_ptr)} < count;
    end
  end

endmodule

// File: rtl/mgt_01_i_wb_arbiter.sv
// Write-back arbiter: buffers execution-unit results and issues up to two
// register-file writes per cycle with rotating priority and same-destination avoidance.
module mgt_01_i_wb_arbiter
  import mgt_01_i_wb_arbiter_pkg::*;
#(
  parameter int unsigned SOURCES     = WB_SOURCES,
  parameter int unsigned DEPTH       = WB_DEPTH,
  parameter int unsigned WRITE_PORTS = WB_WRITE_PORTS
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  mgt_01_i_wb_arbiter_if.slave  bus
);

  localparam int unsigned SW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  logic [SOURCES-1:0] push, pop, full, empty;
  wb_entry_t          din   [SOURCES];
  wb_entry_t          head  [SOURCES];
  wb_entry_t          slots [SOURCES][DEPTH];
  logic [DEPTH-1:0]   slot_valid [SOURCES];

  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] scan [SOURCES];
  logic [SW-1:0] src0, src1, last;
  logic          grant0, grant1;

  for (genvar g = 0; g < SOURCES; g++) begin : g_src
    assign bus.res_ready[g] = clk_en_i & ~full[g];
    // X0 results are acknowledged but never stored.
    assign push[g] = bus.res_valid[g] & bus.res_ready[g] & (bus.res_addr[g] != X0);
    assign din[g]  = {bus.res_addr[g], bus.res_data[g]};

    mgt_01_i_wb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .push    (push[g]),
      .pop     (pop[g]),
      .din     (din[g]),
      .dout    (head[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .entries (slots[g]),
      .valid   (slot_valid[g])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < SOURCES; k++) begin
      scan[k] = SW'(rot_idx(32'(rr_q), k, SOURCES));
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    src0   = '0;
    src1   = '0;
    last   = '0;
    pop    = '0;
    rr_d   = rr_q;
    bus.we = '0;
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      bus.wr_iaddr[p] = X0;
      bus.wr_idata[p] = '0;
    end
    if (clk_en_i) begin
      for (int unsigned k = 0; k < SOURCES; k++) begin
        if (!empty[scan[k]]) begin
          if (!grant0) begin
            grant0 = 1'b1;
            src0   = scan[k];
          end else if (!grant1 && (head[scan[k]].addr != head[src0].addr)) begin
            grant1 = 1'b1;
            src1   = scan[k];
          end
        end
      end
    end
    if (grant0) begin
      pop[src0]       = 1'b1;
      bus.we[0]       = 1'b1;
      bus.wr_iaddr[0] = head[src0].addr;
      bus.wr_idata[0] = head[src0].data;
      last            = grant1 ? src1 : src0;
      rr_d            = (last == SW'(SOURCES - 1)) ? '0 : last + 1'b1;
    end
    if (grant1) begin
      pop[src1]       = 1'b1;
      bus.we[1]       = 1'b1;
      bus.wr_iaddr[1] = head[src1].addr;
      bus.wr_idata[1] = head[src1].data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      rr_q <= '0;
    else if (clk_en_i) rr_q <= rr_d;
  end

  always_comb begin
    bus.pend = '0;
    for (int unsigned s = 0; s < SOURCES; s++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (slot_valid[s][e]) bus.pend[slots[s][e].addr] = 1'b1;
      end
    end
    bus.pend[0] = 1'b0;
  end

endmodule

// File: tb/tb_mgt_01_i_wb_arbiter.sv
// Directed bench for the write-back arbiter: vector table plus clock-enable and async-reset sequences.
module tb_mgt_01_i_wb_arbiter;
  import mgt_01_i_wb_arbiter_pkg::*;

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][4:0]  a;
    logic [3:0][31:0] d;
    logic [1:0]       we;
    logic [4:0]       a0;
    logic [31:0]      d0;
    logic [4:0]       a1;
    logic [31:0]      d1;
    logic [31:0]      pend;
  } vec_t;

  localparam logic [31:0] D0 = 32'hA1A1_0001, D1 = 32'hB2B2_0002;
  localparam logic [31:0] D2 = 32'hC3C3_0003, D3 = 32'hD4D4_0004;
  localparam logic [31:0] E0 = 32'h7070_0000, E1 = 32'h7171_0001;
  localparam logic [31:0] F0 = 32'hF0F0_0000, F1 = 32'hF0F0_0001, F2 = 32'hF0F0_0002;
  localparam logic [31:0] M1 = 32'h3131_0001;
  localparam logic [31:0] K1 = 32'h4141_0001, K2 = 32'h4141_0002, KH = 32'h4141_00FF;

  logic clk, rst_n, clk_en;
  int unsigned n_checks, n_fails;
  vec_t vecs [16];

  mgt_01_i_wb_arbiter_if bus ();

  mgt_01_i_wb_arbiter dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] v, logic [19:0] a, logic [127:0] d, logic [1:0] we,
                              logic [4:0] a0, logic [31:0] d0, logic [4:0] a1, logic [31:0] d1,
                              logic [31:0] pend);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.we = we;
    r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.pend = pend;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] we, input logic [4:0] a0,
                           input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1,
                           input logic [31:0] pend, input logic [3:0] rdy);
    check({tag, " we"},    32'(bus.we),          32'(we));
    check({tag, " addr0"}, 32'(bus.wr_iaddr[0]), 32'(a0));
    check({tag, " data0"}, bus.wr_idata[0],      d0);
    check({tag, " addr1"}, 32'(bus.wr_iaddr[1]), 32'(a1));
    check({tag, " data1"}, bus.wr_idata[1],      d1);
    check({tag, " pend"},  bus.pend,             pend);
    check({tag, " ready"}, 32'(bus.res_ready),   32'(rdy));
  endtask

  task automatic apply_in(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d);
    bus.res_valid = v;
    for (int s = 0; s < 4; s++) begin
      bus.res_addr[s] = i_register_e'(a[s*5 +: 5]);
      bus.res_data[s] = d[s*32 +: 32];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    vecs[0]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {D3, D2, D1, D0}, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[1]  = mk(4'b0000, '0, '0, 2'b11, 5'd1, D0, 5'd2, D1, 32'h0000_001E);
    vecs[2]  = mk(4'b0000, '0, '0, 2'b11, 5'd3, D2, 5'd4, D3, 32'h0000_0018);
    vecs[3]  = mk(4'b0011, {5'd0, 5'd0, 5'd7, 5'd7}, {32'h0, 32'h0, E1, E0}, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[4]  = mk(4'b0000, '0, '0, 2'b01, 5'd7, E0, 5'd0, '0, 32'h0000_0080);
    vecs[5]  = mk(4'b0000, '0, '0, 2'b01, 5'd7, E1, 5'd0, '0, 32'h0000_0080);
    vecs[6]  = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[7]  = mk(4'b0000, '0, '0, 2'b01, 5'd5, 32'h1234_5678, 5'd0, '0, 32'h0000_0020);
    vecs[8]  = mk(4'b0000, '0, '0, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[9]  = mk(4'b1000, '0, {32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0}, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[10] = mk(4'b0000, '0, '0, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[11] = mk(4'b0000, '0, '0, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[12] = mk(4'b0111, {5'd0, 5'd8, 5'd7, 5'd7}, {32'h0, F2, F1, F0}, 2'b00, 5'd0, '0, 5'd0, '0, '0);
    vecs[13] = mk(4'b0000, '0, '0, 2'b11, 5'd7, F1, 5'd8, F2, 32'h0000_0180);
    vecs[14] = mk(4'b0000, '0, '0, 2'b01, 5'd7, F0, 5'd0, '0, 32'h0000_0080);
    vecs[15] = mk(4'b0000, '0, '0, 2'b00, 5'd0, '0, 5'd0, '0, '0);

    rst_n  = 1'b1;
    clk_en = 1'b1;
    apply_in('0, '0, '0);
    #2 rst_n = 1'b0;
    #1 check_out("reset", 2'b00, 5'd0, '0, 5'd0, '0, '0, 4'hF);
    clk_en = 1'b0;
    #1 check("reset ready_en_low", 32'(bus.res_ready), 32'h0);
    clk_en = 1'b1;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_in(vecs[i].v, vecs[i].a, vecs[i].d);
      #2;
      check_out($sformatf("row%0d", i), vecs[i].we, vecs[i].a0, vecs[i].d0,
                vecs[i].a1, vecs[i].d1, vecs[i].pend, 4'hF);
      next_cycle();
    end

    // MUL blocks DIV on X7 so DIV fills; then clock enable is held low.
    apply_in(4'b0110, {5'd0, 5'd7, 5'd7, 5'd0}, {32'h0, K1, M1, 32'h0});
    #2 check_out("ce_c0", 2'b00, 5'd0, '0, 5'd0, '0, '0, 4'hF);
    next_cycle();
    apply_in(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, K2, 32'h0, 32'h0});
    #2 check_out("ce_c1", 2'b01, 5'd7, M1, 5'd0, '0, 32'h0000_0080, 4'hF);
    next_cycle();
    clk_en = 1'b0;
    apply_in(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, KH, 32'h0, 32'h0});
    #2 check_out("ce_low0", 2'b00, 5'd0, '0, 5'd0, '0, 32'h0000_0080, 4'h0);
    next_cycle();
    #2 check_out("ce_low1", 2'b00, 5'd0, '0, 5'd0, '0, 32'h0000_0080, 4'h0);
    next_cycle();
    clk_en = 1'b1;
    #2 check_out("ce_full", 2'b01, 5'd7, K1, 5'd0, '0, 32'h0000_0080, 4'b1011);
    next_cycle();
    #2 check_out("ce_pop1", 2'b01, 5'd7, K2, 5'd0, '0, 32'h0000_0080, 4'hF);
    next_cycle();
    apply_in('0, '0, '0);
    #2 check_out("ce_pop2", 2'b01, 5'd7, KH, 5'd0, '0, 32'h0000_0080, 4'hF);
    next_cycle();
    #2 check_out("ce_done", 2'b00, 5'd0, '0, 5'd0, '0, '0, 4'hF);
    next_cycle();

    // Three entries buffered, then asynchronous reset between edges.
    apply_in(4'b0111, {5'd0, 5'd12, 5'd11, 5'd10}, {32'h0, 32'hCCCC_0012, 32'hBBBB_0011, 32'hAAAA_0010});
    next_cycle();
    apply_in('0, '0, '0);
    #1 check("rst_pre pend", bus.pend, 32'h0000_1C00);
    check("rst_pre we", 32'(bus.we), 32'h3);
    #1 rst_n = 1'b0;
    #1 check_out("rst_mid", 2'b00, 5'd0, '0, 5'd0, '0, '0, 4'hF);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 check_out($sformatf("rst_post%0d", i), 2'b00, 5'd0, '0, 5'd0, '0, '0, 4'hF);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mgt_01_i_wb_arbiter.md
# mgt_01_i_wb_arbiter

Write-back arbiter for the MicroGT-01 integer datapath. It collects results from several execution units (ALU, MUL, DIV, LSU load), buffers them in small per-source FIFOs and drives them onto the two write ports of the integer register file. Each cycle it issues at most one write per port, with rotating priority and same-destination conflict avoidance.

## Interface
Parameters:
- SOURCES, 4, number of result producers (index 0 ALU, 1 MUL, 2 DIV, 3 LSU).
- DEPTH, 2, entries per source FIFO (power of two, ≥2).
- WRITE_PORTS, 2, register-file write ports; fixed at 2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; one clock, asynchronous assert, active-low.
- clk_en_i  in  1  clock enable; low freezes all state.
- res_valid_i  in  SOURCES  result valid per source.
- res_ready_o  out  SOURCES  result accepted when valid&ready at the clock edge.
- res_addr_i  in  SOURCES × i_register_e  destination register per source.
- res_data_i  in  SOURCES × data_bus_t  result value per source.
- we_o  in register-file terms: out  WRITE_PORTS  write enable per port.
- wr_iaddr_o  out  WRITE_PORTS × i_register_e  write address per port.
- wr_idata_o  out  WRITE_PORTS × data_bus_t  write data per port.
- pend_o  out  32  bit r set if any FIFO entry targets register r; bit 0 always 0.

## Operation
- Per-source FIFO holds {addr, data}; count 0..DEPTH. res_ready_o[s] = clk_en_i & (count[s] != DEPTH), from registered count only.
- Push on valid&ready. A result with addr == X0 is accepted and discarded; it is never stored.
- Push and pop on the same FIFO in one cycle: count unchanged, order preserved. A full FIFO never accepts, even if it pops that cycle.
- Rotating pointer rr_q (0..SOURCES-1) sets priority.
- Port 0 selection: scan sources starting at rr_q, wrapping; port 0 takes the first non-empty head.
- Port 1 selection: continue the scan; port 1 takes the next non-empty head whose addr differs from port 0's addr.
- A head with the same addr as port 0 is skipped this cycle. No source issues twice per cycle.
- Granted heads pop.
- rr_q update: if any grant, rr_q ← (index of last granted source + 1) mod SOURCES; otherwise unchanged.
- Ungranted ports: we_o = 0. wr_iaddr_o and wr_idata_o are don't-care but driven to 0.
- clk_en_i low: no push, no pop, rr_q frozen, we_o = 0, res_ready_o = 0.
- pend_o is combinational OR of decoded addr over all valid entries.

## Timing
- Reset (async): all counts 0, rr_q 0, FIFO pointers 0.
  - Outputs under reset: res_ready_o all 1 once clk_en_i is high, we_o 0, wr_* 0, pend_o 0.
  - Reset mid-operation drops all buffered results.
- Latency: result accepted at edge N appears on a write port during cycle N+1 at earliest. The register file captures it at edge N+1.
- we_o, wr_iaddr_o, wr_idata_o and pend_o are combinational from registered FIFO heads, with no path from res_*_i.
- Throughput: 2 writes/cycle sustained when ≥2 sources hold distinct-destination heads.
- Ordering is guaranteed within a source only. Cross-source WAW ordering belongs to the issue stage, which stalls on pend_o.

## Structure
- Add wb_entry_t {i_register_e addr; data_bus_t data;} and SOURCES/DEPTH localparams to Modules_pkg.svh.
- Sub-module: MGT_01_wb_fifo. It is a synchronous FIFO instantiated SOURCES times.
  - Ports: push, pop, entry in/out, full, empty.
  - Also exports all entries plus a valid mask for pend_o.
- Arbiter scan and rr_q logic live in the top module.

## Test plan
- Reset, then ALU pushes (X5, 0x1234_5678) at edge 1 → cycle 2: we_o=01, wr_iaddr_o[0]=X5, wr_idata_o[0]=0x1234_5678; pend_o[5] is 1 in cycle 2 and 0 in cycle 3.
- All four sources push distinct X1..X4 in one cycle, rr_q=0:
  - Cycle +1: ports write X1 (ALU) and X2 (MUL), rr_q→2.
  - Cycle +2: ports write X3 (DIV) and X4 (LSU), rr_q→0.
- ALU and MUL heads both target X7:
  - Cycle +1: only ALU is written (we_o=01).
  - Cycle +2: MUL is written (X7 on port 0).
- LSU pushes X0, 0xDEAD_BEEF → accepted (ready stays 1), no write ever, pend_o stays 0.
- Hold DIV valid with clk_en_i low:
  - Cycles with clk_en_i low: res_ready_o=0, we_o=0.
  - Raise clk_en_i with DIV count=DEPTH → res_ready_o[2]=0 until the first pop.
- Assert rst_n_i low asynchronously between edges with 3 entries buffered → we_o drops to 0 immediately, pend_o=0, no writes after release.
